// File: rtl/bmem_responder.sv
// Memory end of the 64-bit burst interface: 4-beat line reads/writes with fixed latency,
// internal line store, and a sticky protocol-violation flag.
module bmem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        resp,
    output logic        error
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LatWr = 8'(LATENCY - 1);
    // Read leaves WAIT one cycle earlier so the registered first beat lands at T+LATENCY.
    localparam logic [7:0] LatRd = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [2:0] {
        StIdle,
        StWcap,
        StWait,
        StRburst,
        StWack,
        StGap
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    beat_q, beat_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   areq_q, areq_d;
    logic [255:0]  wbuf_q, wbuf_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          resp_q, resp_d;
    logic          error_q, error_d;
    logic          mem_we;
    logic          abort;
    logic [255:0]  rd_line;

    logic [255:0]  mem [DEPTH];

    assign rd_line = mem[areq_d[5 +: IW]];

    // Any change to the held request while a transaction is in flight.
    always_comb begin
        abort = (addr != areq_q);
        if (is_wr_q) begin
            abort = abort || !write || read;
        end else begin
            abort = abort || !read || write;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        is_wr_d = is_wr_q;
        areq_d  = areq_q;
        wbuf_d  = wbuf_q;
        error_d = error_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read && write) begin
                    error_d = 1'b1;
                end else if (read) begin
                    areq_d  = addr;
                    is_wr_d = 1'b0;
                    beat_d  = 2'd0;
                    if (addr[4:0] != 5'd0) error_d = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StRburst;
                    end else begin
                        cnt_d   = LatRd;
                        state_d = StWait;
                    end
                end else if (write) begin
                    areq_d        = addr;
                    is_wr_d       = 1'b1;
                    wbuf_d[63:0]  = wdata;
                    beat_d        = 2'd1;
                    if (addr[4:0] != 5'd0) error_d = 1'b1;
                    state_d       = StWcap;
                end
            end
            StWcap: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                    beat_d  = 2'd0;
                end else begin
                    wbuf_d[{beat_q, 6'd0} +: 64] = wdata;
                    if (beat_q == 2'd3) begin
                        cnt_d   = LatWr;
                        beat_d  = 2'd0;
                        state_d = StWait;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            StWait: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd0) begin
                    if (is_wr_q) begin
                        mem_we  = 1'b1;
                        state_d = StWack;
                    end else begin
                        beat_d  = 2'd0;
                        state_d = StRburst;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRburst: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                    beat_d  = 2'd0;
                end else if (beat_q == 2'd3) begin
                    beat_d  = 2'd0;
                    state_d = StGap;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            StWack: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        resp_d  = (state_d == StRburst) || (state_d == StWack);
        rdata_d = (state_d == StRburst) ? rd_line[{beat_d, 6'd0} +: 64] : 64'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            beat_q  <= 2'd0;
            is_wr_q <= 1'b0;
            areq_q  <= 32'd0;
            wbuf_q  <= 256'd0;
            rdata_q <= 64'd0;
            resp_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            is_wr_q <= is_wr_d;
            areq_q  <= areq_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            error_q <= error_d;
        end
    end

    // Line store is deliberately not reset so committed lines survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[areq_q[5 +: IW]] <= wbuf_q;
        end
    end

    assign rdata = rdata_q;
    assign resp  = resp_q;
    assign error = error_q;

endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: line model plus read-beat scoreboard queue.
module tb_bmem_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 256;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        resp;
    logic        error;

    int tests;
    int fails;

    logic [255:0] model [int];
    logic [63:0]  exp_q [$];

    bmem_responder #(
        .LATENCY(LAT),
        .DEPTH  (DEP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .read (read),
        .write(write),
        .wdata(wdata),
        .rdata(rdata),
        .resp (resp),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_idx(input logic [31:0] a);
        return int'(a[12:5]);
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] b [4];
        b = '{b0, b1, b2, b3};
        addr  = a;
        read  = 1'b0;
        write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wdata = b[k];
            step();
        end
        for (int n = 5; n <= int'(LAT) + 3; n++) begin
            step();
            chk("wr_wait_resp", 64'(resp), 64'd0);
        end
        step();
        chk("wr_resp", 64'(resp), 64'd1);
        step();
        write = 1'b0;
        chk("wr_gap_resp", 64'(resp), 64'd0);
        step();
        model[line_idx(a)] = {b3, b2, b1, b0};
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [255:0] line;
        line = model[line_idx(a)];
        for (int k = 0; k < 4; k++) exp_q.push_back(line[k*64 +: 64]);
        addr  = a;
        write = 1'b0;
        read  = 1'b1;
        for (int n = 1; n <= int'(LAT) + 3; n++) begin
            step();
            if (n < int'(LAT)) begin
                chk("rd_early_resp", 64'(resp), 64'd0);
            end else begin
                chk("rd_resp", 64'(resp), 64'd1);
                if (resp === 1'b1 && exp_q.size() > 0) chk("rd_data", rdata, exp_q.pop_front());
            end
        end
        step();
        chk("rd_gap_resp", 64'(resp), 64'd0);
        read = 1'b0;
        step();
        chk("rd_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic rst_pulse();
        rst   = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        #1;
        chk("rst_resp", 64'(resp), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        addr  = 32'd0;
        read  = 1'b0;
        write = 1'b0;
        wdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp", 64'(resp), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        rst = 1'b0;
        step();

        // Basic write then read-back.
        do_write(32'h0000_0040, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
        chk("wr_error", 64'(error), 64'd0);
        do_read(32'h0000_0040);
        chk("rd_error", 64'(error), 64'd0);

        // Index aliasing: 0x2000 wraps to line 0.
        do_write(32'h0000_0000, {8{8'hA5}}, {8{8'h5A}}, {8{8'hA5}} ^ 64'h1, {8{8'hC3}});
        do_read(32'h0000_2000);
        chk("alias_error", 64'(error), 64'd0);

        // read and write together in IDLE.
        addr  = 32'h0000_0040;
        read  = 1'b1;
        write = 1'b1;
        step();
        chk("both_error", 64'(error), 64'd1);
        for (int n = 0; n < 6; n++) begin
            step();
            chk("both_no_resp", 64'(resp), 64'd0);
        end
        read  = 1'b0;
        write = 1'b0;
        step();
        do_read(32'h0000_0040);
        chk("both_error_sticky", 64'(error), 64'd1);
        rst_pulse();

        // Misaligned read returns the enclosing line.
        do_read(32'h0000_0048);
        chk("misalign_error", 64'(error), 64'd1);
        rst_pulse();

        // Address change during WCAP aborts without committing.
        addr  = 32'h0000_0040;
        write = 1'b1;
        wdata = 64'hDEAD_0000_0000_0000;
        step();
        wdata = 64'hDEAD_0000_0000_0001;
        step();
        addr  = 32'h0000_0060;
        wdata = 64'hDEAD_0000_0000_0002;
        step();
        write = 1'b0;
        addr  = 32'h0000_0040;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("wabort_no_resp", 64'(resp), 64'd0);
        end
        chk("wabort_error", 64'(error), 64'd1);
        do_read(32'h0000_0040);
        rst_pulse();

        // Read dropped in WAIT: no response, then a clean read.
        addr = 32'h0000_0000;
        read = 1'b1;
        step();
        step();
        read = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("rabort_no_resp", 64'(resp), 64'd0);
        end
        chk("rabort_error", 64'(error), 64'd1);
        do_read(32'h0000_0000);

        // Reset during the second write beat discards the partial write.
        addr  = 32'h0000_0040;
        write = 1'b1;
        wdata = 64'hBAD0_BAD0_BAD0_0000;
        step();
        wdata = 64'hBAD0_BAD0_BAD0_0001;
        rst   = 1'b1;
        #1;
        chk("wrst_resp", 64'(resp), 64'd0);
        chk("wrst_rdata", rdata, 64'd0);
        chk("wrst_error", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        write = 1'b0;
        step();
        do_read(32'h0000_0040);

        // Reset mid read burst clears outputs at once.
        addr = 32'h0000_0000;
        read = 1'b1;
        for (int n = 1; n <= int'(LAT) + 1; n++) step();
        chk("rrst_pre_resp", 64'(resp), 64'd1);
        rst = 1'b1;
        #1;
        chk("rrst_resp", 64'(resp), 64'd0);
        chk("rrst_rdata", rdata, 64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        read = 1'b0;
        step();
        do_read(32'h0000_0000);
        chk("final_error", 64'(error), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
